// File: rtl/aes_stream_adapter.sv
// rtl/aes_stream_adapter.sv - 32-bit word stream adapter around the AES_control core
//
// Collects four key words and four plaintext words (MSB word first), starts the core
// through its enable/done handshake, then returns the 128-bit ciphertext as four
// 32-bit words. A watchdog aborts a run that never sees aes_done.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   s_data/s_valid/s_ready       input word stream (key words, then data words)
//   keep_key                     on the final output handshake: 1 = reuse key, load data only
//   m_data/m_valid/m_ready       ciphertext word stream
//   aes_enable/aes_datain/aes_key/aes_dataout/aes_done   core interface
//   busy                         high while running or returning results
//   timeout_err                  sticky abort flag, cleared by the next first key word
module aes_stream_adapter #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         keep_key,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         aes_enable,
  output logic [127:0] aes_datain,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_dataout,
  input  logic         aes_done,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {S_KEY, S_DATA, S_RUN, S_OUT} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     data_q, data_d;
  logic [127:0]     res_q, res_d;
  logic             en_q, en_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] tcnt_inc;
  logic             in_xfer;
  logic             out_xfer;

  // Word 0 lands in the top 32 bits, word 3 in the bottom.
  function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] idx,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = v;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  // A lingering aes_done from the previous run blocks loading.
  assign s_ready  = ((state_q == S_KEY) || (state_q == S_DATA)) && !aes_done;
  assign m_valid  = (state_q == S_OUT);
  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = m_valid && m_ready;
  assign tcnt_inc = tcnt_q + 1'b1;

  assign aes_enable  = en_q;
  assign aes_key     = key_q;
  assign aes_datain  = data_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_OUT);
  assign timeout_err = terr_q;

  always_comb begin
    m_data = 32'h0;
    if (state_q == S_OUT) begin
      case (cnt_q)
        2'd0:    m_data = res_q[127:96];
        2'd1:    m_data = res_q[95:64];
        2'd2:    m_data = res_q[63:32];
        default: m_data = res_q[31:0];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    data_d  = data_q;
    res_d   = res_q;
    en_d    = en_q;
    terr_d  = terr_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_KEY: begin
        if (in_xfer) begin
          key_d = put_word(key_q, cnt_q, s_data);
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) terr_d = 1'b0;
          if (cnt_q == 2'd3) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (in_xfer) begin
          data_d = put_word(data_q, cnt_q, s_data);
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_RUN;
            en_d    = 1'b1;
            tcnt_d  = '0;
          end
        end
      end
      S_RUN: begin
        if (aes_done) begin
          res_d   = aes_dataout;
          en_d    = 1'b0;
          state_d = S_OUT;
        end else if (tcnt_inc == TMO) begin
          // Abort: the partial result is never captured.
          en_d    = 1'b0;
          terr_d  = 1'b1;
          state_d = S_KEY;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      default: begin
        if (out_xfer) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = keep_key ? S_DATA : S_KEY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_KEY;
      cnt_q   <= 2'd0;
      key_q   <= '0;
      data_q  <= '0;
      res_q   <= '0;
      en_q    <= 1'b0;
      terr_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      data_q  <= data_d;
      res_q   <= res_d;
      en_q    <= en_d;
      terr_q  <= terr_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule
